// File: rtl/mux_rr_sched_if.sv
// Requester-side bundle of the round-robin scheduler: four request lines,
// four data words in, and the registered select/grant/transfer outputs.
interface mux_rr_sched_if #(
  parameter int W = 4
);
  logic [3:0]   req;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [1:0]   s;
  logic [3:0]   gnt;
  logic [W-1:0] y;
  logic         vld;
  logic [3:0]   ack;

  // Requester side: drives requests and data, observes grants and transfers.
  modport master (
    output req, a, b, c, d,
    input  s, gnt, y, vld, ack
  );

  // Scheduler side.
  modport slave (
    input  req, a, b, c, d,
    output s, gnt, y, vld, ack
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler in front of a 4:1 W-bit datapath. A winner is picked
// in IDLE, held for up to BURST transferred words in GRANT, then released
// with one idle cycle before the next arbitration. All outputs registered.
module mux_rr_sched #(
  parameter int W     = 4,
  parameter int BURST = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_rr_sched_if.slave bus
);

  localparam int             CW   = (BURST < 2) ? 1 : $clog2(BURST + 1);
  localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    s_q, s_n;
  logic [3:0]    gnt_q, gnt_n;
  logic [W-1:0]  y_q, y_n;
  logic          vld_q, vld_n;
  logic [3:0]    ack_q, ack_n;
  logic [W-1:0]  data_sel;
  logic [1:0]    winner;

  // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    // Scan from the farthest offset down so the nearest set bit wins last.
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // 4:1 datapath mux on the currently granted index.
  always_comb begin
    data_sel = bus.a;
    case (s_q)
      2'd0:    data_sel = bus.a;
      2'd1:    data_sel = bus.b;
      2'd2:    data_sel = bus.c;
      default: data_sel = bus.d;
    endcase
  end

  assign winner = rr_pick(bus.req, ptr);

  // Next-state and next-output logic for the IDLE/GRANT sequencer.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    s_n     = s_q;
    gnt_n   = gnt_q;
    y_n     = y_q;
    vld_n   = 1'b0;
    ack_n   = 4'b0000;
    case (state)
      IDLE: begin
        gnt_n = 4'b0000;
        if (bus.req != 4'b0000) begin
          s_n     = winner;
          gnt_n   = 4'b0001 << winner;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.req[s_q]) begin
          y_n   = data_sel;
          vld_n = 1'b1;
          ack_n = 4'b0001 << s_q;
          cnt_n = cnt + CW'(1);
        end
        // Release on abandon or on the last word of the burst; s is kept.
        if (!bus.req[s_q] || cnt == LAST) begin
          ptr_n   = s_q + 2'd1;
          gnt_n   = 4'b0000;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial burst at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      s_q   <= 2'd0;
      gnt_q <= 4'b0000;
      y_q   <= '0;
      vld_q <= 1'b0;
      ack_q <= 4'b0000;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      s_q   <= s_n;
      gnt_q <= gnt_n;
      y_q   <= y_n;
      vld_q <= vld_n;
      ack_q <= ack_n;
    end
  end

  assign bus.s   = s_q;
  assign bus.gnt = gnt_q;
  assign bus.y   = y_q;
  assign bus.vld = vld_q;
  assign bus.ack = ack_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: BURST=2 instance (dut0) and BURST=1
// instance (dut1). Outputs are packed as {s,gnt,y,vld,ack} and compared
// 1 ns after each rising edge against hand-derived values.
module tb_mux_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [14:0] got, exp;

  always #5 clk = ~clk;

  mux_rr_sched_if #(.W(4)) bus0 ();
  mux_rr_sched_if #(.W(4)) bus1 ();

  mux_rr_sched #(.W(4), .BURST(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mux_rr_sched #(.W(4), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [14:0] snap0();
    return {bus0.s, bus0.gnt, bus0.y, bus0.vld, bus0.ack};
  endfunction

  function automatic logic [14:0] snap1();
    return {bus1.s, bus1.gnt, bus1.y, bus1.vld, bus1.ack};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.req = '0; bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.d = '0;
    bus1.req = '0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.d = '0;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    got = snap0(); exp = '0; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_dut0 got=%h exp=%h", got, exp); end
    got = snap1(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_dut1 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_single_burst();
    logic [14:0] e [5];
    apply_reset();
    bus0.req = 4'b0001; bus0.a = 4'b1111;
    e[0] = {2'd0, 4'b0001, 4'b0000, 1'b0, 4'b0000};
    e[1] = {2'd0, 4'b0001, 4'b1111, 1'b1, 4'b0001};
    e[2] = {2'd0, 4'b0000, 4'b1111, 1'b1, 4'b0001};
    e[3] = {2'd0, 4'b0001, 4'b1111, 1'b0, 4'b0000};
    e[4] = {2'd0, 4'b0000, 4'b1111, 1'b0, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 3) bus0.req = 4'b0000;
      got = snap0(); n_tests++;
      if (got !== e[i]) begin n_fail++; $display("FAIL single_burst[%0d] got=%h exp=%h", i, got, e[i]); end
    end
  endtask

  task automatic test_all_request();
    logic [3:0] dat [4];
    logic [3:0] ylast;
    logic [1:0] k;
    apply_reset();
    dat[0] = 4'b1111; dat[1] = 4'b1110; dat[2] = 4'b1100; dat[3] = 4'b1000;
    bus0.a = dat[0]; bus0.b = dat[1]; bus0.c = dat[2]; bus0.d = dat[3];
    bus0.req = 4'b1111;
    ylast = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      k = 2'(g % 4);
      step();
      got = snap0(); exp = {k, 4'(1) << k, ylast, 1'b0, 4'b0000}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL all_req_grant[%0d] got=%h exp=%h", g, got, exp); end
      step();
      got = snap0(); exp = {k, 4'(1) << k, dat[k], 1'b1, 4'(1) << k}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL all_req_word1[%0d] got=%h exp=%h", g, got, exp); end
      step();
      got = snap0(); exp = {k, 4'b0000, dat[k], 1'b1, 4'(1) << k}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL all_req_word2[%0d] got=%h exp=%h", g, got, exp); end
      ylast = dat[k];
    end
  endtask

  task automatic test_sparse_request();
    logic [1:0] order [3];
    logic [3:0] dat [4];
    logic [3:0] ylast;
    logic [1:0] k;
    apply_reset();
    order[0] = 2'd1; order[1] = 2'd3; order[2] = 2'd1;
    dat[0] = 4'b0000; dat[1] = 4'b0001; dat[2] = 4'b0000; dat[3] = 4'b0011;
    bus0.a = 4'b0101; bus0.b = dat[1]; bus0.c = 4'b1010; bus0.d = dat[3];
    bus0.req = 4'b1010;
    ylast = 4'b0000;
    for (int g = 0; g < 3; g++) begin
      k = order[g];
      step();
      got = snap0(); exp = {k, 4'(1) << k, ylast, 1'b0, 4'b0000}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sparse_grant[%0d] got=%h exp=%h", g, got, exp); end
      step();
      got = snap0(); exp = {k, 4'(1) << k, dat[k], 1'b1, 4'(1) << k}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sparse_word1[%0d] got=%h exp=%h", g, got, exp); end
      step();
      got = snap0(); exp = {k, 4'b0000, dat[k], 1'b1, 4'(1) << k}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL sparse_word2[%0d] got=%h exp=%h", g, got, exp); end
      ylast = dat[k];
    end
  endtask

  task automatic test_abandon();
    apply_reset();
    bus0.req = 4'b0100; bus0.c = 4'b0010; bus0.d = 4'b1001;
    step();
    got = snap0(); exp = {2'd2, 4'b0100, 4'b0000, 1'b0, 4'b0000}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL abandon_grant got=%h exp=%h", got, exp); end
    step();
    got = snap0(); exp = {2'd2, 4'b0100, 4'b0010, 1'b1, 4'b0100}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL abandon_word got=%h exp=%h", got, exp); end
    bus0.req = 4'b0000;
    step();
    got = snap0(); exp = {2'd2, 4'b0000, 4'b0010, 1'b0, 4'b0000}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL abandon_release got=%h exp=%h", got, exp); end
    // ptr should now be 3, so requester 3 wins against all others.
    bus0.req = 4'b1111;
    step();
    got = snap0(); exp = {2'd3, 4'b1000, 4'b0010, 1'b0, 4'b0000}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL abandon_ptr got=%h exp=%h", got, exp); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus0.req = 4'b0100; bus0.c = 4'b0010;
    step();
    step();
    got = snap0(); exp = {2'd2, 4'b0100, 4'b0010, 1'b1, 4'b0100}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL async_pre got=%h exp=%h", got, exp); end
    #3 rst = 1'b1;
    #1;
    got = snap0(); exp = '0; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL async_clear got=%h exp=%h", got, exp); end
    bus0.req = 4'b0110; bus0.b = 4'b0111;
    #2 rst = 1'b0;
    step();
    got = snap0(); exp = {2'd1, 4'b0010, 4'b0000, 1'b0, 4'b0000}; n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL async_regrant got=%h exp=%h", got, exp); end
  endtask

  task automatic test_burst_one();
    logic [3:0] ylast;
    logic [3:0] dk;
    logic [1:0] k;
    apply_reset();
    bus1.req = 4'b1001; bus1.a = 4'b0110; bus1.d = 4'b0101;
    bus1.b = 4'b1111; bus1.c = 4'b1111;
    ylast = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      k  = (g % 2 == 0) ? 2'd0 : 2'd3;
      dk = (g % 2 == 0) ? 4'b0110 : 4'b0101;
      step();
      got = snap1(); exp = {k, 4'(1) << k, ylast, 1'b0, 4'b0000}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL burst1_grant[%0d] got=%h exp=%h", g, got, exp); end
      step();
      got = snap1(); exp = {k, 4'b0000, dk, 1'b1, 4'(1) << k}; n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL burst1_word[%0d] got=%h exp=%h", g, got, exp); end
      ylast = dk;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_burst();
    test_all_request();
    test_sparse_request();
    test_abandon();
    test_async_reset();
    test_burst_one();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
